// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed program as a byte stream and
// writes it word-by-word into instruction memory port A, holding the CPU in
// reset until every word has been written.
module imem_boot_loader #(
    parameter int size          = 32,
    parameter int MemSize       = 512,
    parameter int AddrWidth     = 9,
    parameter int TimeoutCycles = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_valid,
    input  logic [7:0]           i_rx_data,
    output logic                 o_rx_ready,
    output logic                 o_imem_wea,
    output logic [AddrWidth-1:0] o_imem_addra,
    output logic [size-1:0]      o_imem_dina,
    output logic                 o_cpu_reset,
    output logic                 o_load_done,
    output logic                 o_load_error,
    output logic [AddrWidth:0]   o_words_loaded
);

    localparam int TW  = $clog2(TimeoutCycles + 1);
    localparam int PAD = 16 - (AddrWidth + 1);

    typedef enum logic [3:0] {
        S_START, S_HDR_HI, S_HDR_LO, S_BYTE0, S_BYTE1,
        S_BYTE2, S_BYTE3, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [15:0]           r_len;
    logic [23:0]           r_buf;
    logic [AddrWidth:0]    r_cnt;
    logic [AddrWidth-1:0]  r_addr;
    logic [size-1:0]       r_dina;
    logic [TW-1:0]         r_to;
    logic                  r_cpu_reset;
    logic                  r_load_done;

    logic                  w_accept;
    logic                  w_wait;
    logic                  w_timeout;
    logic [15:0]           w_n;
    logic [AddrWidth:0]    w_cnt_inc;

    assign w_accept  = i_rx_valid & o_rx_ready;
    assign w_wait    = (r_state == S_HDR_LO) || (r_state == S_BYTE0) || (r_state == S_BYTE1) ||
                       (r_state == S_BYTE2) || (r_state == S_BYTE3);
    // The idle counter is checked one short so the fault lands on the
    // TimeoutCycles-th idle edge rather than one edge later.
    assign w_timeout = (r_to == TW'(TimeoutCycles - 1));
    assign w_n       = {r_len[15:8], i_rx_data};
    assign w_cnt_inc = r_cnt + 1'b1;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_START;
        else         r_state <= w_next;
    end

    // Next-state decode: header parsing, byte sequencing, write and timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_START:  w_next = S_HDR_HI;
            S_HDR_HI: if (w_accept) w_next = S_HDR_LO;
            S_HDR_LO: begin
                if (w_accept) begin
                    if (w_n == 16'd0)                w_next = S_DONE;
                    else if (w_n > 16'(MemSize))     w_next = S_ERROR;
                    else                             w_next = S_BYTE0;
                end else if (w_timeout) begin
                    w_next = S_ERROR;
                end
            end
            S_BYTE0:  if (w_accept) w_next = S_BYTE1; else if (w_timeout) w_next = S_ERROR;
            S_BYTE1:  if (w_accept) w_next = S_BYTE2; else if (w_timeout) w_next = S_ERROR;
            S_BYTE2:  if (w_accept) w_next = S_BYTE3; else if (w_timeout) w_next = S_ERROR;
            S_BYTE3:  if (w_accept) w_next = S_WRITE; else if (w_timeout) w_next = S_ERROR;
            S_WRITE:  w_next = ({{PAD{1'b0}}, w_cnt_inc} == r_len) ? S_DONE : S_BYTE0;
            S_DONE:   w_next = S_DONE;
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_START;
        endcase
    end

    // Output decode from the registered state only
    always_comb begin
        o_rx_ready   = w_wait || (r_state == S_HDR_HI);
        o_imem_wea   = (r_state == S_WRITE);
        o_load_error = (r_state == S_ERROR);
    end

    // Byte capture, word assembly, counters and the CPU release flags.
    // Release is registered off DONE so the CPU leaves reset one edge after
    // the final write has retired.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_len       <= '0;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_dina      <= '0;
            r_to        <= '0;
            r_cpu_reset <= 1'b1;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= (r_state == S_DONE);
            r_cpu_reset <= (r_state != S_DONE);
            if (w_accept) begin
                case (r_state)
                    S_HDR_HI: r_len[15:8]  <= i_rx_data;
                    S_HDR_LO: r_len[7:0]   <= i_rx_data;
                    S_BYTE0:  r_buf[23:16] <= i_rx_data;
                    S_BYTE1:  r_buf[15:8]  <= i_rx_data;
                    S_BYTE2:  r_buf[7:0]   <= i_rx_data;
                    S_BYTE3: begin
                        r_dina <= size'({r_buf, i_rx_data});
                        r_addr <= r_cnt[AddrWidth-1:0];
                    end
                    default: ;
                endcase
            end
            if (r_state == S_WRITE) r_cnt <= w_cnt_inc;
            if (w_accept || !w_wait) r_to <= '0;
            else                     r_to <= r_to + 1'b1;
        end
    end

    assign o_imem_addra   = r_addr;
    assign o_imem_dina    = r_dina;
    assign o_cpu_reset    = r_cpu_reset;
    assign o_load_done    = r_load_done;
    assign o_words_loaded = r_cnt;

endmodule
